// File: rtl/hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller (freeze/redirect/load-use) with a
//               freeze watchdog. Define HAZARD_PERF_CNT_EN for stall/flush
//               performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      id_instr_i,
    input  logic             id_rs1_use_i,
    input  logic             id_rs2_use_i,
    input  logic [31:0]      ex_instr_i,
    input  logic             ex_is_load_i,
    input  logic             ex_rd_wren_i,
    input  logic             ex_br_taken_i,
    input  logic             mem_busy_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             ex_mem_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_BUBBLE   = 2'd1,
        ST_FREEZE   = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    localparam int                 c_frz_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_frz_w-1:0] c_frz_max = c_frz_w'(TIMEOUT_CYCLES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_frz_w-1:0] r_frz_cnt;
    logic [c_frz_w-1:0] w_frz_nxt;
    logic               r_timeout;
    logic [4:0]         w_rs1;
    logic [4:0]         w_rs2;
    logic [4:0]         w_ex_rd;
    logic               w_load_use;
    logic               w_unused_bits;

    assign w_rs1   = id_instr_i[19:15];
    assign w_rs2   = id_instr_i[24:20];
    assign w_ex_rd = ex_instr_i[11:7];

    assign w_unused_bits = ^{id_instr_i[31:25], id_instr_i[14:0],
                             ex_instr_i[31:12], ex_instr_i[6:0]};

    assign w_load_use = ex_is_load_i && ex_rd_wren_i && (w_ex_rd != 5'd0) &&
                        (((w_ex_rd == w_rs1) && id_rs1_use_i) ||
                         ((w_ex_rd == w_rs2) && id_rs2_use_i));

    // Controls depend only on the current inputs; r_state contributes just
    // the one-cycle load-use mask right after a bubble.
    always_comb begin
        pc_en_o       = 1'b1;
        if_id_en_o    = 1'b1;
        id_ex_en_o    = 1'b1;
        ex_mem_en_o   = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        w_state_nxt   = ST_RUN;
        if (rst_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (mem_busy_i) begin
            pc_en_o     = 1'b0;
            if_id_en_o  = 1'b0;
            id_ex_en_o  = 1'b0;
            ex_mem_en_o = 1'b0;
            w_state_nxt = ST_FREEZE;
        end else if (ex_br_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            w_state_nxt   = ST_REDIRECT;
        end else if (w_load_use && (r_state != ST_BUBBLE)) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
            w_state_nxt   = ST_BUBBLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_frz_nxt = !mem_busy_i               ? '0        :
                       (r_frz_cnt == c_frz_max)  ? r_frz_cnt :
                                                   r_frz_cnt + c_frz_w'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_frz_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_frz_cnt <= w_frz_nxt;
            if (w_frz_nxt == c_frz_max) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((w_state_nxt == ST_BUBBLE) || (w_state_nxt == ST_FREEZE)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_state_nxt == ST_REDIRECT) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Randomized scoreboard bench for hazard_ctrl against a
//               cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int T = 255;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] id_instr_i;
    logic        id_rs1_use_i;
    logic        id_rs2_use_i;
    logic [31:0] ex_instr_i;
    logic        ex_is_load_i;
    logic        ex_rd_wren_i;
    logic        ex_br_taken_i;
    logic        mem_busy_i;
    logic        pc_en_o;
    logic        if_id_en_o;
    logic        id_ex_en_o;
    logic        ex_mem_en_o;
    logic        if_id_flush_o;
    logic        id_ex_flush_o;
    logic        timeout_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .TIMEOUT_CYCLES(T),
        .CNT_W         (32)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .id_instr_i   (id_instr_i),
        .id_rs1_use_i (id_rs1_use_i),
        .id_rs2_use_i (id_rs2_use_i),
        .ex_instr_i   (ex_instr_i),
        .ex_is_load_i (ex_is_load_i),
        .ex_rd_wren_i (ex_rd_wren_i),
        .ex_br_taken_i(ex_br_taken_i),
        .mem_busy_i   (mem_busy_i),
        .pc_en_o      (pc_en_o),
        .if_id_en_o   (if_id_en_o),
        .id_ex_en_o   (id_ex_en_o),
        .ex_mem_en_o  (ex_mem_en_o),
        .if_id_flush_o(if_id_flush_o),
        .id_ex_flush_o(id_ex_flush_o),
        .timeout_o    (timeout_o),
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o)
    );

    typedef struct {
        logic [6:0]  ctrl;
        logic [31:0] stall;
        logic [31:0] flush;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;

    // Model state: previous cycle inserted a bubble, freeze run length,
    // sticky watchdog, event counters.
    bit          m_bub   = 1'b0;
    int          m_frz   = 0;
    bit          m_to    = 1'b0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_flush = '0;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit busy, input bit br, input bit ld, input bit wr,
                         input bit u1, input bit u2, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        exp_t e;
        bit   lu, frz, red, bub;
        @(posedge clk);
        #1;
        rst_i         = rst;
        mem_busy_i    = busy;
        ex_br_taken_i = br;
        ex_is_load_i  = ld;
        ex_rd_wren_i  = wr;
        id_rs1_use_i  = u1;
        id_rs2_use_i  = u2;
        id_instr_i    = $urandom;
        id_instr_i[19:15] = rs1;
        id_instr_i[24:20] = rs2;
        ex_instr_i    = $urandom;
        ex_instr_i[11:7] = rd;

        e.cyc   = cyc;
        cyc++;
        e.stall = m_stall;
        e.flush = m_flush;
        if (rst) begin
            e.ctrl  = {4'b1111, 2'b11, m_to};
            m_bub   = 1'b0;
            m_frz   = 0;
            m_to    = 1'b0;
            m_stall = '0;
            m_flush = '0;
        end else begin
            lu  = ld && wr && (rd != 5'd0) && (((rd == rs1) && u1) || ((rd == rs2) && u2));
            frz = busy;
            red = !busy && br;
            bub = !busy && !br && lu && !m_bub;
            e.ctrl = {!frz && !bub, !frz && !bub, !frz, !frz, red, red || bub, m_to};
            m_bub = bub;
            m_frz = busy ? ((m_frz + 1 > T) ? T : m_frz + 1) : 0;
            if (m_frz == T) m_to = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
            if (frz || bub) m_stall = m_stall + 32'd1;
            if (red)        m_flush = m_flush + 32'd1;
`endif
        end
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ctrl{pc,ifid,idex,exmem,ifid_fl,idex_fl,to}", e.cyc,
                    {25'd0, pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o,
                     if_id_flush_o, id_ex_flush_o, timeout_o}, {25'd0, e.ctrl});
                chk("stall_cnt", e.cyc, stall_cnt_o, e.stall);
                chk("flush_cnt", e.cyc, flush_cnt_o, e.flush);
            end
        end
    end

    initial begin
        rst_i = 1'b1; mem_busy_i = 1'b0; ex_br_taken_i = 1'b0; ex_is_load_i = 1'b0;
        ex_rd_wren_i = 1'b0; id_rs1_use_i = 1'b0; id_rs2_use_i = 1'b0;
        id_instr_i = 32'h0000_0013; ex_instr_i = 32'h0000_0013;
        repeat (2) @(posedge clk);

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // lw x5 then add x6,x5,x1
        drive(0, 0, 0, 1, 1, 1, 1, 5, 5, 1);
        drive(0, 0, 0, 0, 0, 1, 1, 0, 6, 5);
        // hazard persisting right after a bubble is masked once
        drive(0, 0, 0, 1, 1, 0, 1, 7, 3, 7);
        drive(0, 0, 0, 1, 1, 0, 1, 7, 3, 7);
        drive(0, 0, 0, 1, 1, 0, 1, 7, 3, 7);
        // load to x0 never stalls
        drive(0, 0, 0, 1, 1, 1, 1, 0, 0, 0);
        // branch wins over load-use
        drive(0, 0, 1, 1, 1, 1, 0, 5, 5, 1);
        // freeze with pending branch, redirect when busy falls
        repeat (3) drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // bubble, freeze, then the hazard is re-evaluated
        drive(0, 0, 0, 1, 1, 1, 0, 9, 9, 2);
        drive(0, 1, 0, 1, 1, 1, 0, 9, 9, 2);
        drive(0, 0, 0, 1, 1, 1, 0, 9, 9, 2);
        drive(0, 0, 0, 1, 1, 1, 0, 9, 9, 2);
        // watchdog
        repeat (260) drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // reset in the middle of a freeze
        repeat (4) drive(0, 1, 0, 1, 1, 1, 1, 2, 2, 2);
        drive(1, 1, 1, 1, 1, 1, 1, 2, 2, 2);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 63) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 1) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 0,
                  $urandom_range(0, 1) == 0,
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. It drives the enable and flush inputs of the IF_ID, ID_EX and EX_MEM pipeline registers and the PC enable. It does this from the instruction in ID, the instruction held in ID_EX, branch resolution in EX and the data-memory ready status. A flush of ID_EX loads a NOP (0x00000013) with all control fields zero, which is the register's reset content. A freeze watchdog and optional stall/flush counters support debug and performance analysis.

## Interface
- TIMEOUT_CYCLES, 255: number of consecutive freeze cycles after which timeout_o sets.
- CNT_W, 32: width of the performance counters.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- id_instr_i  in  32  instruction in ID; rs1 = [19:15], rs2 = [24:20].
- id_rs1_use_i  in  1  ID instruction reads rs1.
- id_rs2_use_i  in  1  ID instruction reads rs2 (is_rs2).
- ex_instr_i  in  32  instruction held in ID_EX; rd = [11:7].
- ex_is_load_i  in  1  ID_EX holds a load.
- ex_rd_wren_i  in  1  ID_EX instruction writes rd.
- ex_br_taken_i  in  1  branch or jump in EX resolved taken.
- mem_busy_i  in  1  data memory not ready this cycle.
- pc_en_o  out  1  PC update enable.
- if_id_en_o, id_ex_en_o, ex_mem_en_o  out  1 each  pipeline register enables.
- if_id_flush_o, id_ex_flush_o  out  1 each  load NOP/zero controls on the next edge.
- timeout_o  out  1  sticky freeze-watchdog flag.
- stall_cnt_o, flush_cnt_o  out  CNT_W each  performance counters (see Configuration).

## Operation
Hazards are evaluated combinationally every cycle. Priority order: FREEZE > REDIRECT > LOAD_USE > RUN.

- **FREEZE** (mem_busy_i = 1)
  - All enables 0, all flushes 0.
  - The entire pipeline holds. A taken branch or a load-use hazard present at the same time is deferred, because EX is frozen and the condition persists.
- **REDIRECT** (ex_br_taken_i = 1, not frozen)
  - All enables 1.
  - if_id_flush_o = 1 and id_ex_flush_o = 1, squashing the two wrong-path instructions.
- **LOAD_USE** (not frozen, not redirecting)
  - Condition: ex_is_load_i & ex_rd_wren_i & rd != 0 & ((rd == rs1 & id_rs1_use_i) | (rd == rs2 & id_rs2_use_i)).
  - pc_en_o = 0 and if_id_en_o = 0.
  - id_ex_en_o = 1 with id_ex_flush_o = 1, inserting one bubble.
  - ex_mem_en_o = 1.
- **RUN**
  - All enables 1, all flushes 0.

Registered state machine (state_q): RUN, BUBBLE, FREEZE, REDIRECT.
- state_q records the case selected in the previous cycle.
- The controls above are a function of the current inputs only; state_q does not gate them.
- The only exception: in BUBBLE, the load-use condition is masked for exactly one cycle as a guard against double bubbles.

Freeze watchdog:
- frz_cnt increments each cycle mem_busy_i = 1, saturating at TIMEOUT_CYCLES.
- frz_cnt clears on any cycle with mem_busy_i = 0.
- timeout_o sets on the edge where frz_cnt reaches TIMEOUT_CYCLES and stays set until reset.

Reset:
- state_q = RUN, frz_cnt = 0, timeout_o = 0, counters = 0.
- While rst_i = 1, all enables = 1 and all flushes = 1, so every pipeline register loads its NOP/zero state.

## Timing
- All control outputs are combinational from the inputs and state_q, valid in the same cycle; the pipeline registers act on the next edge.
- Load-use costs exactly 1 bubble cycle. Taken branch costs 2 squashed slots.
- A freeze lasting N cycles costs N cycles. Once mem_busy_i falls, the deferred event resolves in that same cycle.
- Reset mid-freeze or mid-bubble: state and watchdog return to reset values on the next edge. Deasserting rst_i gives RUN in the following cycle.
- The BUBBLE mask lasts exactly one cycle even if a freeze follows. After the freeze, the hazard is re-evaluated normally.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt_o increments on every LOAD_USE or FREEZE cycle.
  - flush_cnt_o increments on every REDIRECT cycle.
  - Both wrap modulo 2^CNT_W and clear on reset.
- Not defined: stall_cnt_o and flush_cnt_o are tied to 0 and no counter registers exist.

## Test plan
- lw x5 in EX, add x6,x5,x1 in ID (rs1 use) -> one cycle of pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1, ex_mem_en_o=1; RUN the next cycle; stall_cnt_o=1.
- lw x0 in EX, consumer reads x0 -> no stall; all enables 1.
- ex_br_taken_i=1 together with a load-use hazard -> REDIRECT: both flushes 1, pc_en_o=1; flush_cnt_o=1.
- mem_busy_i=1 for 3 cycles with ex_br_taken_i=1 -> all enables 0 for 3 cycles, then REDIRECT in the cycle busy falls.
- mem_busy_i held 255 cycles (TIMEOUT_CYCLES=255) -> timeout_o=1 from cycle 256 and remains 1 after busy drops; rst_i clears it.
- rst_i asserted during a freeze -> all enables 1, all flushes 1, counters 0; RUN after release.
